// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the register-file writeback arbiter.
//   AW / DW / NREG : register index width, data width, register count
//   ZERO_REG       : hard-wired zero register, never written, never busy
//   REQ_ALU/REQ_MEM: requester ids, also the bit positions in req/gnt vectors
//   wb_req_t       : one writeback request (destination index + data)
//   reg_onehot     : one-hot register mask for scoreboard set/clear
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;

    localparam logic [AW-1:0] ZERO_REG = 5'd0;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MEM = 1'b1;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } wb_req_t;

    function automatic logic [NREG-1:0] reg_onehot(input logic [AW-1:0] r);
        return NREG'(1) << r;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bus between the writeback requesters / decode and the arbiter.
//   alu_*   : ALU writeback request (valid, reg, data) and its ready
//   mem_*   : load writeback request (valid, reg, data) and its ready
//   issue_* : decode issue of an instruction that will write issue_reg
//   busy_mask : registers with an issued, not yet committed write
//   write / write_reg / write_data : registered write port to register_file
//
// Handshake: a requester raises valid with a stable payload and holds both
// until it sees ready in the same cycle; a transfer happens on any cycle
// where valid && ready. ready is a combinational function of the valids.
//
// Modports: slave = the arbiter, master = requesters / decode / bench.
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if;
    import regfile_pkg::*;

    logic            alu_valid;
    logic [AW-1:0]   alu_reg;
    logic [DW-1:0]   alu_data;
    logic            alu_ready;

    logic            mem_valid;
    logic [AW-1:0]   mem_reg;
    logic [DW-1:0]   mem_data;
    logic            mem_ready;

    logic            issue_valid;
    logic [AW-1:0]   issue_reg;
    logic [NREG-1:0] busy_mask;

    logic            write;
    logic [AW-1:0]   write_reg;
    logic [DW-1:0]   write_data;

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        output alu_ready,
        input  mem_valid, mem_reg, mem_data,
        output mem_ready,
        input  issue_valid, issue_reg,
        output busy_mask,
        output write, write_reg, write_data
    );

    modport master (
        output alu_valid, alu_reg, alu_data,
        input  alu_ready,
        output mem_valid, mem_reg, mem_data,
        input  mem_ready,
        output issue_valid, issue_reg,
        input  busy_mask,
        input  write, write_reg, write_data
    );

endinterface

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-requester arbiter, combinational grant, one registered tie pointer.
//   cclk      : clock
//   rst       : synchronous active-high reset; forces gnt=0 while high
//   req[1:0]  : request vector (bit REQ_ALU, bit REQ_MEM)
//   fixed_pri : 1 = REQ_MEM always wins a tie, 0 = round-robin
//   gnt[1:0]  : one-hot grant, zero when nothing is requested
// The pointer names the requester that wins the next tie. It only moves
// on a contested cycle and then points at that cycle's loser, so an
// uncontested grant never costs the other requester its turn.
// ---------------------------------------------------------------------------
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       cclk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       fixed_pri,
    output logic [1:0] gnt
);

    logic r_ptr;
    logic w_ptr_next;

    always_ff @(posedge cclk) begin
        if (rst) begin
            r_ptr <= REQ_ALU;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

    always_comb begin
        gnt        = 2'b00;
        w_ptr_next = r_ptr;
        if (!rst) begin
            unique case (req)
                2'b01: gnt = 2'b01;
                2'b10: gnt = 2'b10;
                2'b11: begin
                    if (fixed_pri || (r_ptr == REQ_MEM)) begin
                        gnt        = 2'b10;
                        w_ptr_next = REQ_ALU;
                    end else begin
                        gnt        = 2'b01;
                        w_ptr_next = REQ_MEM;
                    end
                end
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single register_file write port between the ALU and the load
// unit, registers the winning write, and keeps the RAW busy scoreboard.
//   cclk : clock, all state on posedge
//   rst  : synchronous active-high reset
//   bus  : regfile_wb_arbiter_if.slave (requests, readies, issue,
//          busy_mask, write / write_reg / write_data)
// Parameter FIXED_PRI: 0 = round-robin, 1 = load always wins a tie.
//
// A transfer to ZERO_REG is accepted but produces write=0; write_reg and
// write_data still take its payload, since they follow every transfer and
// hold only on cycles with no transfer at all.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic                 cclk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    logic [1:0]      w_req;
    logic [1:0]      w_gnt;
    logic            w_xfer;
    wb_req_t         w_win;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_busy_next;

    logic            r_write;
    logic [AW-1:0]   r_write_reg;
    logic [DW-1:0]   r_write_data;
    logic [NREG-1:0] r_busy;

    assign w_req[REQ_ALU] = bus.alu_valid;
    assign w_req[REQ_MEM] = bus.mem_valid;

    rr_arbiter2 u_arb (
        .cclk      (cclk),
        .rst       (rst),
        .req       (w_req),
        .fixed_pri (FIXED_PRI),
        .gnt       (w_gnt)
    );

    assign bus.alu_ready = w_gnt[REQ_ALU];
    assign bus.mem_ready = w_gnt[REQ_MEM];
    assign w_xfer        = |w_gnt;

    always_comb begin
        w_win.idx  = bus.alu_reg;
        w_win.data = bus.alu_data;
        if (w_gnt[REQ_MEM]) begin
            w_win.idx  = bus.mem_reg;
            w_win.data = bus.mem_data;
        end
    end

    // The clear comes from the registered commit, so a register stays busy
    // through its commit cycle. OR-ing the set after the clear makes a
    // same-cycle re-issue win: the new producer is still outstanding.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (bus.issue_valid) begin
            w_set = reg_onehot(bus.issue_reg);
        end
        if (r_write) begin
            w_clr = reg_onehot(r_write_reg);
        end
        w_busy_next    = (r_busy & ~w_clr) | w_set;
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge cclk) begin
        if (rst) begin
            r_write      <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_busy       <= '0;
        end else begin
            r_write <= w_xfer && (w_win.idx != ZERO_REG);
            if (w_xfer) begin
                r_write_reg  <= w_win.idx;
                r_write_data <= w_win.data;
            end
            r_busy <= w_busy_next;
        end
    end

    assign bus.write      = r_write;
    assign bus.write_reg  = r_write_reg;
    assign bus.write_data = r_write_data;
    assign bus.busy_mask  = r_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Two DUT instances (round-robin and fixed priority) driven by independent
// requesters. A transaction-level model predicts readies, the write port
// and busy_mask; a compare process checks them every cycle. Directed
// sequences add literal expectations, then a random phase runs.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic cclk = 1'b0;
  logic rst  = 1'b1;
  always #5 cclk = ~cclk;

  // ---------------- stimulus and observed signals, index = DUT ----------
  logic            d_av[2], d_mv[2], d_iv[2];
  logic [AW-1:0]   d_ar[2], d_mr[2], d_ir[2];
  logic [DW-1:0]   d_ad[2], d_md[2];
  logic            o_ar[2], o_mr[2], o_w[2];
  logic [AW-1:0]   o_wr[2];
  logic [DW-1:0]   o_wd[2];
  logic [NREG-1:0] o_busy[2];

  regfile_wb_arbiter_if bus0();
  regfile_wb_arbiter_if bus1();

  regfile_wb_arbiter #(.FIXED_PRI(1'b0)) u_dut0 (.cclk(cclk), .rst(rst), .bus(bus0));
  regfile_wb_arbiter #(.FIXED_PRI(1'b1)) u_dut1 (.cclk(cclk), .rst(rst), .bus(bus1));

  assign bus0.alu_valid = d_av[0];  assign bus1.alu_valid = d_av[1];
  assign bus0.alu_reg   = d_ar[0];  assign bus1.alu_reg   = d_ar[1];
  assign bus0.alu_data  = d_ad[0];  assign bus1.alu_data  = d_ad[1];
  assign bus0.mem_valid = d_mv[0];  assign bus1.mem_valid = d_mv[1];
  assign bus0.mem_reg   = d_mr[0];  assign bus1.mem_reg   = d_mr[1];
  assign bus0.mem_data  = d_md[0];  assign bus1.mem_data  = d_md[1];
  assign bus0.issue_valid = d_iv[0]; assign bus1.issue_valid = d_iv[1];
  assign bus0.issue_reg   = d_ir[0]; assign bus1.issue_reg   = d_ir[1];
  assign o_ar[0] = bus0.alu_ready;  assign o_ar[1] = bus1.alu_ready;
  assign o_mr[0] = bus0.mem_ready;  assign o_mr[1] = bus1.mem_ready;
  assign o_w[0]  = bus0.write;      assign o_w[1]  = bus1.write;
  assign o_wr[0] = bus0.write_reg;  assign o_wr[1] = bus1.write_reg;
  assign o_wd[0] = bus0.write_data; assign o_wd[1] = bus1.write_data;
  assign o_busy[0] = bus0.busy_mask; assign o_busy[1] = bus1.busy_mask;

  // ---------------- scoreboard counters ----------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ------------------------------------
  // Per DUT: who won the last tie, the pending register-file write, and the
  // set of registers with an outstanding producer.
  bit              m_init = 1'b0;
  bit              m_last_tie_mem[2];
  logic            m_w[2];
  logic [AW-1:0]   m_wr[2];
  logic [DW-1:0]   m_wd[2];
  logic [NREG-1:0] m_busy[2];

  // Which requester is accepted right now (bit0 = alu, bit1 = mem).
  function automatic logic [1:0] exp_gnt(input int k);
    if (rst) return 2'b00;
    if (d_av[k] && d_mv[k]) begin
      if (k == 1) return 2'b10;
      return m_last_tie_mem[k] ? 2'b01 : 2'b10;
    end
    return {d_mv[k], d_av[k]};
  endfunction

  always @(posedge cclk) begin
    for (int k = 0; k < 2; k++) begin
      logic [1:0]      g;
      logic [NREG-1:0] nb;
      g = exp_gnt(k);
      if (rst) begin
        m_w[k] = 1'b0; m_wr[k] = '0; m_wd[k] = '0; m_busy[k] = '0;
        m_last_tie_mem[k] = 1'b1;
      end else begin
        nb = m_busy[k];
        if (m_w[k]) nb[m_wr[k]] = 1'b0;
        if (d_iv[k]) nb[d_ir[k]] = 1'b1;
        nb[0] = 1'b0;
        if (d_av[k] && d_mv[k]) m_last_tie_mem[k] = g[1];
        m_w[k] = 1'b0;
        if (g[0]) begin m_wr[k] = d_ar[k]; m_wd[k] = d_ad[k]; m_w[k] = (d_ar[k] != 0); end
        if (g[1]) begin m_wr[k] = d_mr[k]; m_wd[k] = d_md[k]; m_w[k] = (d_mr[k] != 0); end
        m_busy[k] = nb;
      end
    end
    if (rst) m_init = 1'b1;
  end

  // ---------------- compare process --------------------------------------
  always @(negedge cclk) begin
    if (m_init) begin
      for (int k = 0; k < 2; k++) begin
        logic [1:0] g;
        g = exp_gnt(k);
        check($sformatf("d%0d alu_ready", k), o_ar[k], g[0]);
        check($sformatf("d%0d mem_ready", k), o_mr[k], g[1]);
        check($sformatf("d%0d write", k), o_w[k], m_w[k]);
        check($sformatf("d%0d write_reg", k), o_wr[k], m_wr[k]);
        check($sformatf("d%0d write_data", k), o_wd[k], m_wd[k]);
        check($sformatf("d%0d busy_mask", k), o_busy[k], m_busy[k]);
        if (d_iv[k] && d_ir[k] != 0)
          assert (!o_busy[k][d_ir[k]] || (o_w[k] && o_wr[k] == d_ir[k]))
            else $error("decode issued to busy register %0d on dut %0d", d_ir[k], k);
      end
    end
  end

  // ---------------- driver helpers ---------------------------------------
  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      d_av[k] = 0; d_mv[k] = 0; d_iv[k] = 0;
    end
  endtask

  // Called between negedge and next posedge: requesters that were accepted
  // get a fresh payload after the edge; the others hold theirs.
  task automatic step_hold();
    bit aa[2], ma[2];
    for (int k = 0; k < 2; k++) begin
      aa[k] = d_av[k] && o_ar[k];
      ma[k] = d_mv[k] && o_mr[k];
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      if (aa[k]) begin d_ar[k] = AW'($urandom_range(1, 31)); d_ad[k] = $urandom; end
      if (ma[k]) begin d_mr[k] = AW'($urandom_range(1, 31)); d_md[k] = $urandom; end
    end
  endtask

  int wait_a, wait_m;

  // ---------------- main sequence ----------------------------------------
  initial begin
    for (int k = 0; k < 2; k++) begin
      d_av[k] = 1; d_mv[k] = 1; d_iv[k] = 0;
      d_ar[k] = 5'd1; d_ad[k] = 32'h1111_0000;
      d_mr[k] = 5'd2; d_md[k] = 32'h2222_0000;
      d_ir[k] = '0;
    end
    rst = 1'b1;

    // Reset held with both requesters valid.
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge cclk);
      for (int k = 0; k < 2; k++) begin
        check($sformatf("rst d%0d write", k), o_w[k], 1'b0);
        check($sformatf("rst d%0d busy", k), o_busy[k], '0);
        check($sformatf("rst d%0d alu_ready", k), o_ar[k], 1'b0);
        check($sformatf("rst d%0d mem_ready", k), o_mr[k], 1'b0);
      end
    end
    tick();
    rst = 1'b0;

    // Contention: round-robin alternates from alu, fixed priority keeps mem.
    for (int i = 0; i < 4; i++) begin
      @(negedge cclk);
      check($sformatf("rr grant%0d alu", i), o_ar[0], (i % 2) == 0);
      check($sformatf("rr grant%0d mem", i), o_mr[0], (i % 2) == 1);
      check($sformatf("fix grant%0d alu", i), o_ar[1], 1'b0);
      check($sformatf("fix grant%0d mem", i), o_mr[1], 1'b1);
      step_hold();
    end
    d_mv[0] = 0; d_mv[1] = 0;
    @(negedge cclk);
    check("drain d0 alu", o_ar[0], 1'b1);
    check("drain d1 alu", o_ar[1], 1'b1);
    tick();
    idle_all();

    // Single request: one-cycle write, then idle.
    d_av[0] = 1; d_ar[0] = 5'd5; d_ad[0] = 32'hDEAD_BEEF;
    @(negedge cclk);
    check("single alu_ready", o_ar[0], 1'b1);
    tick();
    d_av[0] = 0;
    @(negedge cclk);
    check("single write", o_w[0], 1'b1);
    check("single write_reg", o_wr[0], 5'd5);
    check("single write_data", o_wd[0], 32'hDEAD_BEEF);
    tick();
    @(negedge cclk);
    check("single write off", o_w[0], 1'b0);
    check("single reg hold", o_wr[0], 5'd5);
    tick();

    // Zero register: accepted, no write, never busy.
    d_mv[0] = 1; d_mr[0] = 5'd0; d_md[0] = 32'h0000_1234;
    d_iv[0] = 1; d_ir[0] = 5'd0;
    @(negedge cclk);
    check("zero mem_ready", o_mr[0], 1'b1);
    tick();
    d_mv[0] = 0; d_iv[0] = 0;
    @(negedge cclk);
    check("zero write", o_w[0], 1'b0);
    check("zero busy0", o_busy[0][0], 1'b0);
    tick();

    // Scoreboard: set, clear after commit, re-issue on the commit cycle.
    d_iv[0] = 1; d_ir[0] = 5'd7;
    @(negedge cclk);
    tick();
    d_iv[0] = 0;
    d_av[0] = 1; d_ar[0] = 5'd7; d_ad[0] = 32'hA5A5_A5A5;
    @(negedge cclk);
    check("sb busy7 set", o_busy[0][7], 1'b1);
    tick();
    d_av[0] = 0;
    @(negedge cclk);
    check("sb commit write", o_w[0], 1'b1);
    check("sb busy7 thru commit", o_busy[0][7], 1'b1);
    tick();
    d_av[0] = 1; d_ar[0] = 5'd7; d_ad[0] = 32'h0000_1111;
    @(negedge cclk);
    check("sb busy7 cleared", o_busy[0][7], 1'b0);
    tick();
    d_av[0] = 0;
    d_iv[0] = 1; d_ir[0] = 5'd7;
    @(negedge cclk);
    check("sb recommit write_reg", o_wr[0], 5'd7);
    tick();
    d_iv[0] = 0;
    @(negedge cclk);
    check("sb set wins", o_busy[0][7], 1'b1);
    tick();

    // Reset mid-operation with 0xF0 busy and a transfer in flight.
    for (int r = 4; r <= 6; r++) begin
      d_iv[0] = 1; d_ir[0] = AW'(r);
      @(negedge cclk);
      tick();
    end
    d_iv[0] = 0;
    d_av[0] = 1; d_ar[0] = 5'd9; d_ad[0] = 32'hCAFE_0009;
    @(negedge cclk);
    check("mid busy F0", o_busy[0], 32'h0000_00F0);
    tick();
    d_av[0] = 0;
    rst = 1'b1;
    @(negedge cclk);
    check("mid write N+1", o_w[0], 1'b1);
    tick();
    rst = 1'b0;
    @(negedge cclk);
    check("mid write N+2", o_w[0], 1'b0);
    check("mid busy N+2", o_busy[0], '0);
    tick();

    // Random phase.
    wait_a = 0; wait_m = 0;
    for (int c = 0; c < 3000; c++) begin
      bit aa[2], ma[2];
      @(negedge cclk);
      for (int k = 0; k < 2; k++) begin
        aa[k] = d_av[k] && o_ar[k];
        ma[k] = d_mv[k] && o_mr[k];
      end
      if (rst) begin
        wait_a = 0; wait_m = 0;
      end else begin
        if (d_av[0]) begin
          if (o_ar[0]) begin check("rr alu wait", wait_a <= 1, 1'b1); wait_a = 0; end
          else wait_a++;
        end
        if (d_mv[0]) begin
          if (o_mr[0]) begin check("rr mem wait", wait_m <= 1, 1'b1); wait_m = 0; end
          else wait_m++;
        end
      end
      tick();
      rst = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < 2; k++) begin
        int r;
        if (!d_av[k] || aa[k]) begin
          d_av[k] = ($urandom_range(0, 2) != 0);
          d_ar[k] = AW'($urandom_range(0, 31));
          d_ad[k] = $urandom;
        end
        if (!d_mv[k] || ma[k]) begin
          d_mv[k] = ($urandom_range(0, 2) != 0);
          d_mr[k] = AW'($urandom_range(0, 31));
          d_md[k] = $urandom;
        end
        r = $urandom_range(0, 31);
        d_ir[k] = AW'(r);
        d_iv[k] = ($urandom_range(0, 2) == 0) && !m_busy[k][r];
      end
    end
    @(negedge cclk);
    idle_all();
    rst = 1'b0;
    repeat (2) @(posedge cclk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
